uart_tx_fifo_param: RTL and testbench

//  Parametrised serial transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
//  A FIFO_DEPTH-entry input FIFO lets the host queue several words; frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_fifo_param.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// Serial transmitter with a small input FIFO: start bit, DATA_WIDTH data bits LSB first,
// optional parity, 1 or 2 stop bits; queued frames go out back-to-back.
module uart_tx_fifo_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                start,
    output logic                                tx,
    output logic                                ready,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT-1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH-1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS-1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("uart_tx_fifo_param: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                  state_q, state_d;
    logic [CLK_W-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, ready_q, ovf_q, pend_q;
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   head;
    logic                    push, pop, bit_end, head_par;

    assign head     = mem_q[rptr_q];
    assign head_par = (PARITY_MODE == 2) ? ~^head : ^head;
    // A full FIFO refuses writes even when a pop frees a slot on the same edge.
    assign push     = start && (count_q != FULL);
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign bit_end  = (clk_cnt_q == CLK_LAST);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= data_in;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CLK_W'(1);
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                tx_d      = 1'b1;
                // pend_q delays launch one edge after a write lands in an empty FIFO.
                if (pend_q && count_q != '0) begin
                    pop = 1'b1; shreg_d = head; par_d = head_par;
                    state_d = S_START; tx_d = 1'b0;
                end
            end
            S_START: if (bit_end) begin
                clk_cnt_d = '0; bit_cnt_d = '0;
                state_d = S_DATA; tx_d = shreg_q[0];
            end
            S_DATA: if (bit_end) begin
                clk_cnt_d = '0;
                shreg_d   = shreg_q >> 1;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (PARITY_MODE != 0) begin state_d = S_PARITY; tx_d = par_q; end
                    else begin state_d = S_STOP; tx_d = 1'b1; end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    tx_d      = shreg_q[1];
                end
            end
            S_PARITY: if (bit_end) begin
                clk_cnt_d = '0; bit_cnt_d = '0;
                state_d = S_STOP; tx_d = 1'b1;
            end
            S_STOP: if (bit_end) begin
                clk_cnt_d = '0;
                if (bit_cnt_q == STOP_LAST) begin
                    bit_cnt_d = '0;
                    if (count_q != '0) begin
                        pop = 1'b1; shreg_d = head; par_d = head_par;
                        state_d = S_START; tx_d = 1'b0;
                    end else begin
                        state_d = S_IDLE; tx_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: begin state_d = S_IDLE; tx_d = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != S_IDLE);
            ready_q   <= (count_d != FULL);
            ovf_q     <= start && (count_q == FULL);
            pend_q    <= (count_q != '0);
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q   <= count_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: a queue-level line model checks the default instance every
// cycle; directed frames on four parameter sets are checked against hand-computed waveforms.
module tb_uart_tx_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data8 = '0;
    logic [6:0] data7 = '0;
    logic       start0 = 0, start1 = 0, start2 = 0, start3 = 0;
    logic       tx0, tx1, tx2, tx3, ready0, ready1, ready2, ready3;
    logic       busy0, busy1, busy2, busy3, overflow0, overflow1, overflow2, overflow3;
    logic [2:0] fifo_count0, fifo_count1, fifo_count2, fifo_count3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_param u_d0 (.clk(clk), .rst(rst), .data_in(data8), .start(start0), .tx(tx0),
        .ready(ready0), .busy(busy0), .fifo_count(fifo_count0), .overflow(overflow0));
    uart_tx_fifo_param #(.PARITY_MODE(2)) u_d1 (.clk(clk), .rst(rst), .data_in(data8),
        .start(start1), .tx(tx1), .ready(ready1), .busy(busy1), .fifo_count(fifo_count1),
        .overflow(overflow1));
    uart_tx_fifo_param #(.PARITY_MODE(0)) u_d2 (.clk(clk), .rst(rst), .data_in(data8),
        .start(start2), .tx(tx2), .ready(ready2), .busy(busy2), .fifo_count(fifo_count2),
        .overflow(overflow2));
    uart_tx_fifo_param #(.DATA_WIDTH(7), .STOP_BITS(2)) u_d3 (.clk(clk), .rst(rst),
        .data_in(data7), .start(start3), .tx(tx3), .ready(ready3), .busy(busy3),
        .fifo_count(fifo_count3), .overflow(overflow3));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line model of the default instance: a queue of accepted words stamped with their edge,
    // and the current frame as a bit list; each line bit lasts 16 cycles, a frame 176.
    typedef struct { logic [7:0] w; int t; } ent_t;
    ent_t        mq[$];
    int          cyc = 0, sz, m_pos = 0;
    bit          m_busy = 0, m_valid = 0, acc;
    logic [10:0] m_bits = '1;
    logic        e_tx, e_busy, e_rdy, e_ovf;
    int          e_cnt;

    task automatic m_load();
        ent_t e;
        e = mq.pop_front();
        m_bits = {1'b1, ^e.w, e.w, 1'b0};
        m_busy = 1; m_pos = 0;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            mq.delete(); m_busy = 0; m_pos = 0; e_ovf = 0; m_valid = 1;
        end else begin
            sz    = mq.size();
            acc   = start0 && sz < 4;
            e_ovf = start0 && sz == 4;
            if (m_busy) begin
                m_pos++;
                if (m_pos == 176) begin
                    m_busy = 0;
                    if (sz != 0) m_load();
                end
            end else if (sz != 0 && mq[0].t <= cyc - 2) m_load();
            if (acc) mq.push_back('{data8, cyc});
        end
        e_tx   = m_busy ? m_bits[m_pos/16] : 1'b1;
        e_busy = m_busy;
        e_cnt  = mq.size();
        e_rdy  = mq.size() < 4;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (tx0 !== e_tx || busy0 !== e_busy || fifo_count0 !== 3'(e_cnt) ||
                ready0 !== e_rdy || overflow0 !== e_ovf) begin
                errors++;
                if (errors < 40)
                    $display("FAIL model t=%0d: tx/busy/cnt/rdy/ovf got %b/%b/%0d/%b/%b expected %b/%b/%0d/%b/%b",
                             cyc, tx0, busy0, fifo_count0, ready0, overflow0,
                             e_tx, e_busy, e_cnt, e_rdy, e_ovf);
            end
        end
    end

    // Statistics on the default instance, cleared by the stimulus at a rising edge.
    int run0 = 0, last_run0 = 0, peak0 = 0, ovf_cyc0 = 0;
    bit saw_full0 = 0;
    always @(negedge clk) begin
        if (busy0) run0++;
        else begin
            if (run0 != 0) last_run0 = run0;
            run0 = 0;
        end
        if (int'(fifo_count0) > peak0) peak0 = int'(fifo_count0);
        if (overflow0) ovf_cyc0++;
        if (!ready0) saw_full0 = 1;
    end

    function automatic logic tx_of(input int s);
        case (s) 0: return tx0; 1: return tx1; 2: return tx2; default: return tx3; endcase
    endfunction
    function automatic logic busy_of(input int s);
        case (s) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s) 0: start0 = v; 1: start1 = v; 2: start2 = v; default: start3 = v; endcase
    endtask

    // Single write, then sample each line bit mid-period and measure frame and stop lengths.
    task automatic run_frame(input int s, input logic [7:0] word, input int nbits,
                             input logic [15:0] exp_bits, input int exp_len,
                             input int exp_tail, input string name);
        int lat, len, tail;
        logic [15:0] got, mask;
        @(negedge clk);
        data8 = word; data7 = word[6:0]; set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        lat = 1;
        while (!busy_of(s) && lat < 20) begin @(negedge clk); lat++; end
        chk({name, " latency"}, lat, 3);
        len = 0; tail = 0; got = '0;
        while (busy_of(s) && len < 400) begin
            if (len % 16 == 8) got[len/16] = tx_of(s);
            if (tx_of(s)) tail++; else tail = 0;
            len++;
            @(negedge clk);
        end
        mask = 16'((1 << nbits) - 1);
        chk({name, " bits"}, int'(got & mask), int'(exp_bits));
        chk({name, " length"}, len, exp_len);
        chk({name, " stop high"}, tail, exp_tail);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle0(input int budget, input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((busy0 || fifo_count0 != 0) && n < budget) begin @(negedge clk); n++; end
        chk({name, " drained in budget"}, int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] w4 [4];
    bit rose;

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset tx", tx0, 1);
        chk("reset ready", ready0, 1);
        chk("reset busy", busy0, 0);
        chk("reset count", fifo_count0, 0);
        chk("reset overflow", overflow0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        run_frame(0, 8'hA5, 11, 16'h54A, 176, 16, "A5 even");
        run_frame(1, 8'h01, 11, 16'h402, 176, 16, "01 odd");
        run_frame(0, 8'h01, 11, 16'h602, 176, 32, "01 even");
        run_frame(2, 8'h01, 10, 16'h202, 160, 16, "01 none");
        run_frame(3, 8'h55, 11, 16'h6AA, 176, 32, "55 w7 two stop");

        // Four writes on consecutive edges: four contiguous frames.
        w4[0] = 8'hA1; w4[1] = 8'hB2; w4[2] = 8'hC3; w4[3] = 8'hD4;
        @(posedge clk); peak0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); start0 = 1'b1; data8 = w4[i];
        end
        @(negedge clk); start0 = 1'b0;
        wait_idle0(1500, "burst4");
        chk("burst4 peak count", peak0, 3);
        chk("burst4 busy run", last_run0, 704);

        // Six writes: five accepted, one overflow pulse.
        @(posedge clk); peak0 = 0; ovf_cyc0 = 0; saw_full0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); start0 = 1'b1; data8 = 8'(8'h10 + i);
        end
        @(negedge clk); start0 = 1'b0;
        wait_idle0(1500, "burst6");
        chk("burst6 overflow cycles", ovf_cyc0, 1);
        chk("burst6 peak count", peak0, 4);
        chk("burst6 ready went low", int'(saw_full0), 1);
        chk("burst6 busy run", last_run0, 880);

        // Reset in the middle of the data bits with two words still queued.
        @(negedge clk); start0 = 1'b1; data8 = 8'h11;
        @(negedge clk); data8 = 8'h22;
        @(negedge clk); data8 = 8'h33;
        @(negedge clk); start0 = 1'b0;
        repeat (60) @(negedge clk);
        chk("pre-abort count", fifo_count0, 2);
        chk("pre-abort busy", busy0, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort tx", tx0, 1);
        chk("abort busy", busy0, 0);
        chk("abort count", fifo_count0, 0);
        rst = 1'b1;
        rose = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy0 || !tx0) rose = 1;
        end
        chk("no frame after abort", int'(rose), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
